image_stream_ctrl: RTL and testbench

- Sequences reads from the 7840x8 pixel ROM holding 10 MNIST-style 28x28 images.
- On a start request, streams one selected image to the network input layer, pixel by pixel, over a valid/ready handshake with backpressure.
- Sits between the top-level control FSM and the first neural layer; owns the ROM address bus.

---
 rtl/image_stream_ctrl.sv | 121 ++++++++++++
 tb/tb_image_stream_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/image_stream_ctrl.sv
// rtl/image_stream_ctrl.sv - streams one 28x28 image from the pixel ROM over a valid/ready handshake
// Optional IMG_STREAM_CHECKSUM_EN adds a 16-bit running sum of accepted pixels.
module image_stream_ctrl #(
   parameter int IMG_PIXELS = 784,
   parameter int NUM_IMAGES = 10,
   parameter int ADDR_W     = 13,
   parameter int DATA_W     = 8,
   parameter int IDX_W      = 10,
   parameter int SEL_W      = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [SEL_W-1:0]  img_sel,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] pix_data,
   output logic [IDX_W-1:0]  pix_idx,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic              pix_last,
   output logic              busy,
   output logic              done,
   output logic              err
`ifdef IMG_STREAM_CHECKSUM_EN
   ,
   output logic [15:0]       checksum
`endif
);

   localparam logic [SEL_W-1:0]  NUM_IMG_S = SEL_W'(NUM_IMAGES);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(IMG_PIXELS - 1);
   localparam logic [ADDR_W-1:0] IMG_PIX_A = ADDR_W'(IMG_PIXELS);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] base;
   logic [IDX_W-1:0]  fetch_idx;
   logic              load, sel_ok, last_fetch, xfer, accept_start;

   assign sel_ok       = (img_sel < NUM_IMG_S);
   assign last_fetch   = (fetch_idx == LAST_IDX);
   assign xfer         = pix_valid && pix_ready;
   assign accept_start = (state == IDLE) && start && sel_ok;
   assign rom_addr     = base + ADDR_W'(fetch_idx);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start && sel_ok)   state_nxt = STREAM;
         STREAM:  if (load && last_fetch) state_nxt = DRAIN;
         DRAIN:   if (xfer)              state_nxt = IDLE;
         default:                        state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      load = (state == STREAM) && (!pix_valid || pix_ready);
   end

   // fetch_idx stops at the last index so no address past the image is ever issued
   always_ff @(posedge clk) begin
      if (rst) begin
         base      <= '0;
         fetch_idx <= '0;
         pix_data  <= '0;
         pix_idx   <= '0;
         pix_valid <= 1'b0;
         pix_last  <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (sel_ok) begin
                     base      <= ADDR_W'(img_sel) * IMG_PIX_A;
                     fetch_idx <= '0;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            STREAM: begin
               if (load) begin
                  pix_data  <= rom_data;
                  pix_idx   <= fetch_idx;
                  pix_valid <= 1'b1;
                  pix_last  <= last_fetch;
                  if (!last_fetch) fetch_idx <= fetch_idx + IDX_W'(1);
               end
            end
            DRAIN: begin
               if (xfer) begin
                  pix_valid <= 1'b0;
                  pix_last  <= 1'b0;
                  done      <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef IMG_STREAM_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (rst || accept_start) checksum <= 16'h0000;
      else if (xfer)           checksum <= checksum + 16'(pix_data);
   end
`endif

endmodule

// File: tb/tb_image_stream_ctrl.sv
// tb/tb_image_stream_ctrl.sv - directed self-checking bench for image_stream_ctrl
module tb_image_stream_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  img_sel;
   logic [12:0] rom_addr;
   logic [7:0]  rom_data;
   logic [7:0]  pix_data;
   logic [9:0]  pix_idx;
   logic        pix_valid;
   logic        pix_ready;
   logic        pix_last;
   logic        busy;
   logic        done;
   logic        err;
`ifdef IMG_STREAM_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic logic [7:0] romval(input int a);
      int v;
      v = a * 37 + (a >> 5);
      return v[7:0];
   endfunction

   assign rom_data = romval(int'(rom_addr));

   image_stream_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .img_sel(img_sel),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .pix_data(pix_data), .pix_idx(pix_idx), .pix_valid(pix_valid),
      .pix_ready(pix_ready), .pix_last(pix_last),
      .busy(busy), .done(done), .err(err)
`ifdef IMG_STREAM_CHECKSUM_EN
      , .checksum(checksum)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // mode 0: ready always high; mode 1: ready pattern 1,0,0,1 by cycle
   task automatic run_image(input int sel, input int mode, input int abort_idx, input int inject_k);
      int         base, k, exp_idx;
      bit         finished, aborted, prev_stall;
      logic [7:0] prev_data;
      logic [9:0] prev_idx;
      logic       prev_last;
      logic [15:0] sum_exp;
      base = sel * 784;
      finished = 0; aborted = 0; prev_stall = 0; exp_idx = 0; sum_exp = 16'h0;
      prev_data = '0; prev_idx = '0; prev_last = 1'b0;
      @(negedge clk);
      start = 1'b1; img_sel = 4'(sel); pix_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 1;
      check("first_addr", 32'(rom_addr), 32'(base));
      check("busy_after_start", 32'(busy), 32'd1);
      while (!finished && !aborted && k < 6000) begin
         if (k == inject_k) begin
            start = 1'b1; img_sel = 4'd12;
         end else begin
            start = 1'b0;
         end
         pix_ready = (mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
         check("no_err_in_stream", 32'(err), 32'd0);
         if (done) begin
            check("all_pixels", 32'(exp_idx), 32'd784);
            if (mode == 0) check("done_latency", 32'(k), 32'd786);
            check("addr_after_done", 32'(rom_addr), 32'(base + 783));
`ifdef IMG_STREAM_CHECKSUM_EN
            check("checksum", 32'(checksum), 32'(sum_exp));
`endif
            finished = 1;
         end else begin
            if (busy) check("addr_in_range",
               32'((int'(rom_addr) >= base) && (int'(rom_addr) <= base + 783)), 32'd1);
            if (pix_valid) begin
               if (prev_stall) begin
                  check("hold_data", 32'(pix_data), 32'(prev_data));
                  check("hold_idx",  32'(pix_idx),  32'(prev_idx));
                  check("hold_last", 32'(pix_last), 32'(prev_last));
               end
               check("pix_idx",  32'(pix_idx),  32'(exp_idx));
               check("pix_data", 32'(pix_data), 32'(romval(base + exp_idx)));
               check("pix_last", 32'(pix_last), 32'(exp_idx == 783));
               if (int'(pix_idx) == abort_idx) begin
                  rst = 1'b1;
                  aborted = 1;
               end else if (pix_ready) begin
                  sum_exp = sum_exp + 16'(pix_data);
                  exp_idx++;
                  prev_stall = 0;
               end else begin
                  prev_stall = 1;
                  prev_data = pix_data; prev_idx = pix_idx; prev_last = pix_last;
               end
            end
         end
         if (!finished) begin
            @(negedge clk);
            k++;
         end
      end
      start = 1'b0;
      if (aborted) begin
         @(negedge clk);
         rst = 1'b0;
         check("rst_valid", 32'(pix_valid), 32'd0);
         check("rst_busy",  32'(busy),      32'd0);
         check("rst_addr",  32'(rom_addr),  32'd0);
         check("rst_done",  32'(done),      32'd0);
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_done_after_rst", 32'(done), 32'd0);
         end
      end else begin
         check("finished_in_budget", 32'(finished), 32'd1);
         @(negedge clk);
         check("done_one_cycle", 32'(done), 32'd0);
         check("busy_low_after_done", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; img_sel = 4'd0; pix_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_valid", 32'(pix_valid), 32'd0);
      check("reset_busy",  32'(busy),      32'd0);
      check("reset_addr",  32'(rom_addr),  32'd0);
      check("reset_done",  32'(done),      32'd0);
      check("reset_err",   32'(err),       32'd0);
      check("reset_idx",   32'(pix_idx),   32'd0);
      check("reset_data",  32'(pix_data),  32'd0);
      check("reset_last",  32'(pix_last),  32'd0);
      rst = 1'b0;

      run_image(0, 0, -1, -1);
      run_image(9, 0, -1, -1);
      run_image(3, 1, -1, -1);

      @(negedge clk);
      start = 1'b1; img_sel = 4'd10;
      @(negedge clk);
      start = 1'b0;
      check("err_pulse",      32'(err),      32'd1);
      check("err_busy",       32'(busy),     32'd0);
      check("err_addr_hold",  32'(rom_addr), 32'd3135);
      check("err_no_done",    32'(done),     32'd0);
      @(negedge clk);
      check("err_one_cycle",  32'(err),      32'd0);
      check("err_stay_idle",  32'(busy),     32'd0);

      run_image(1, 0, -1, 100);
      run_image(2, 0, 400, -1);
      run_image(2, 0, -1, -1);
      run_image(0, 1, -1, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
